// File: rtl/fanout_tree_pipe.sv
// fanout_tree_pipe
//   Pipelined, parametrised inverter/buffer fan-out tree. One input bit runs
//   through CHAIN_LEN registers and then through a registered binary tree of
//   depth log2(NUM_OUT) to NUM_OUT leaf registers. Every stage inverts
//   (inv_mode=1) or buffers (inv_mode=0). A fill counter tracks how many
//   enabled edges have passed since the last restart (reset or mode change),
//   and a saturating counter records dout[0] transitions while valid.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         stage enable; 0 freezes all pipeline state and the fill count
//   inv_mode   1: every stage inverts, 0: every stage buffers
//   din        data input
//   cnt_clr    synchronous clear of toggle_cnt (wins over an increment)
//   dout       leaf outputs, one register per leaf, all bits always equal
//   dout_valid registered; 1 when every stage holds data captured since the
//              last restart
//   toggle_cnt saturating count of dout[0] transitions seen while valid
//
// Output qualification: dout_valid is a plain status flag, not a handshake.
// There is no ready/backpressure; dout is meaningful on any cycle where
// dout_valid=1 and is ignored otherwise. All outputs come straight from
// registers, so no input reaches an output combinationally.

module fanout_tree_pipe #(
  parameter int NUM_OUT   = 4,
  parameter int CHAIN_LEN = 5,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inv_mode,
  input  logic               din,
  input  logic               cnt_clr,
  output logic [NUM_OUT-1:0] dout,
  output logic               dout_valid,
  output logic [CNT_W-1:0]   toggle_cnt
);

  localparam int L      = $clog2(NUM_OUT);
  localparam int LAT    = CHAIN_LEN + L;
  localparam int FILL_W = $clog2(LAT + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LAT);
  // Tree nodes use heap numbering: node 1 is the root (last chain stage),
  // children of node n are 2n and 2n+1. Level j occupies nodes
  // 2^(j+1) .. 2^(j+2)-1, so the leaves are nodes NUM_OUT .. 2*NUM_OUT-1.
  localparam int NODES  = 2 * NUM_OUT;

  logic                 mode_q;
  logic                 mode_chg;
  logic [CHAIN_LEN-1:0] chain;
  logic [NODES-1:2]     tree;
  logic [NODES-1:2]     parent;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_nxt;
  logic                 d0_q;

  // A mode change is seen regardless of en; it restarts the fill count.
  assign mode_chg = (inv_mode != mode_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= inv_mode;
    end
  end

  // Register chain. Stage 0 captures din; each later stage its predecessor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (en) begin
      chain[0] <= din ^ inv_mode;
      for (int i = 1; i < CHAIN_LEN; i++) begin
        chain[i] <= chain[i-1] ^ inv_mode;
      end
    end
  end

  // Parent wiring of the tree: level-0 nodes (2 and 3) hang off the root.
  for (genvar n = 2; n < NODES; n++) begin : g_node
    if (n < 4) begin : g_root_child
      assign parent[n] = chain[CHAIN_LEN-1];
    end else begin : g_inner_child
      assign parent[n] = tree[n/2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree <= '0;
    end else if (en) begin
      tree <= parent ^ {(NODES-2){inv_mode}};
    end
  end

  assign dout = tree[NODES-1:NUM_OUT];

  // Fill tracking: counts enabled edges since the last restart, saturating
  // at LAT. dout_valid is registered from the next fill value so it rises on
  // the same edge the count reaches LAT.
  always_comb begin
    fill_nxt = fill;
    if (mode_chg) begin
      fill_nxt = '0;
    end else if (en && (fill != FILL_MAX)) begin
      fill_nxt = fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill       <= '0;
      dout_valid <= 1'b0;
    end else begin
      fill       <= fill_nxt;
      dout_valid <= (fill_nxt == FILL_MAX);
    end
  end

  // Toggle tracking: d0_q is dout[0] delayed one edge, so a transition of
  // dout[0] is counted on the edge after it happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q       <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      d0_q <= dout[0];
      if (cnt_clr) begin
        toggle_cnt <= '0;
      end else if (dout_valid && (dout[0] != d0_q) && (toggle_cnt != '1)) begin
        toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end

endmodule
